// File: rtl/missile_pkg.sv
// ============================================================================
// missile_pkg : shared state encoding and geometry for the player missile
// Rev 1.0
// ============================================================================
`default_nettype none

package missile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } missile_state_e;

  localparam logic [9:0] MISSILE_W  = 10'd2;
  localparam logic [9:0] MISSILE_H  = 10'd8;
  localparam logic [9:0] SCREEN_TOP = 10'd0;

  // Unsigned subtract that clamps at zero instead of wrapping.
  function automatic logic [9:0] sat_sub10(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : 10'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/missile_hit_detect.sv
// ============================================================================
// missile_hit_detect : N-way box overlap test with lowest-index priority
// Rev 1.0
// ============================================================================
`default_nettype none

module missile_hit_detect #(
  parameter int num_enemies_p = 8
) (
  input  logic [9:0]                  left_i,
  input  logic [9:0]                  right_i,
  input  logic [9:0]                  top_i,
  input  logic [9:0]                  bot_i,
  input  logic [10*num_enemies_p-1:0] enemy_left_i,
  input  logic [10*num_enemies_p-1:0] enemy_right_i,
  input  logic [10*num_enemies_p-1:0] enemy_top_i,
  input  logic [10*num_enemies_p-1:0] enemy_bot_i,
  input  logic [num_enemies_p-1:0]    enemy_dead_i,
  output logic                        any_hit_o,
  output logic [num_enemies_p-1:0]    hit_vec_o
);

  logic [num_enemies_p-1:0] overlap;

  for (genvar k = 0; k < num_enemies_p; k++) begin : g_ship
    assign overlap[k] = ~enemy_dead_i[k]
                      & (left_i  <= enemy_right_i[10*k +: 10])
                      & (right_i >= enemy_left_i[10*k +: 10])
                      & (top_i   <= enemy_bot_i[10*k +: 10])
                      & (bot_i   >= enemy_top_i[10*k +: 10]);
  end

  assign any_hit_o = |overlap;

  // Scan high to low so the lowest overlapping index is the one that sticks.
  always_comb begin
    hit_vec_o = '0;
    for (int k = num_enemies_p - 1; k >= 0; k--) begin
      if (overlap[k]) begin
        hit_vec_o    = '0;
        hit_vec_o[k] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/player_missile.sv
// ============================================================================
// player_missile : player projectile, launches on fire edge, climbs per frame,
// strobes hit_o on the first enemy it touches. MISSILE_COOLDOWN_EN adds a
// post-flight lockout of cooldown_p frames.
// Rev 1.0
// ============================================================================
`default_nettype none

module player_missile
  import missile_pkg::*;
#(
  parameter int          num_enemies_p = 8,
  parameter logic [9:0]  speed_p       = 10'd4,
  parameter logic [11:0] color_p       = 12'hFFF,
  parameter logic [3:0]  cooldown_p    = 4'd8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        frame_i,
  input  logic                        fire_i,
  input  logic [9:0]                  cannon_x_i,
  input  logic [9:0]                  cannon_top_i,
  input  logic [10*num_enemies_p-1:0] enemy_left_i,
  input  logic [10*num_enemies_p-1:0] enemy_right_i,
  input  logic [10*num_enemies_p-1:0] enemy_top_i,
  input  logic [10*num_enemies_p-1:0] enemy_bot_i,
  input  logic [num_enemies_p-1:0]    enemy_dead_i,
  output logic [num_enemies_p-1:0]    hit_o,
  output logic                        miss_o,
  output logic                        active_o,
  output logic [9:0]                  left_o,
  output logic [9:0]                  right_o,
  output logic [9:0]                  top_o,
  output logic [9:0]                  bot_o,
  output logic [11:0]                 color_o
);

  missile_state_e           state_q, state_d;
  logic                     fire_q;
  logic [9:0]               left_q, left_d, right_q, right_d;
  logic [9:0]               top_q, top_d, bot_q, bot_d;
  logic [num_enemies_p-1:0] hit_q, hit_d;
  logic                     miss_q, miss_d;
  logic                     any_hit;
  logic [num_enemies_p-1:0] hit_vec;
  logic                     fire_edge;
  logic                     flight_end;

`ifdef MISSILE_COOLDOWN_EN
  logic [3:0]               cool_q, cool_d;
`else
  // cooldown_p has no role without the cool-down phase.
  logic [3:0]               cooldown_unused;
  assign cooldown_unused = cooldown_p;
`endif

  missile_hit_detect #(.num_enemies_p(num_enemies_p)) u_hit_detect (
    .left_i        (left_q),
    .right_i       (right_q),
    .top_i         (top_q),
    .bot_i         (bot_q),
    .enemy_left_i  (enemy_left_i),
    .enemy_right_i (enemy_right_i),
    .enemy_top_i   (enemy_top_i),
    .enemy_bot_i   (enemy_bot_i),
    .enemy_dead_i  (enemy_dead_i),
    .any_hit_o     (any_hit),
    .hit_vec_o     (hit_vec)
  );

  assign fire_edge = fire_i & ~fire_q;

  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    right_d    = right_q;
    top_d      = top_q;
    bot_d      = bot_q;
    hit_d      = '0;
    miss_d     = 1'b0;
    flight_end = 1'b0;
`ifdef MISSILE_COOLDOWN_EN
    cool_d     = cool_q;
`endif
    case (state_q)
      IDLE: begin
        if (fire_edge) begin
          state_d = FLY;
          left_d  = sat_sub10(cannon_x_i, 10'd1);
          right_d = left_d + MISSILE_W - 10'd1;
          top_d   = sat_sub10(cannon_top_i, MISSILE_H);
          bot_d   = top_d + MISSILE_H - 10'd1;
        end
      end
      FLY: begin
        // A hit in the same cycle as frame_i takes precedence over the move.
        if (any_hit) begin
          hit_d      = hit_vec;
          flight_end = 1'b1;
        end else if (frame_i) begin
          if (top_q < SCREEN_TOP + speed_p) begin
            miss_d     = 1'b1;
            flight_end = 1'b1;
          end else begin
            top_d = top_q - speed_p;
            bot_d = bot_q - speed_p;
          end
        end
      end
`ifdef MISSILE_COOLDOWN_EN
      COOL: begin
        if (frame_i) begin
          if (cool_q <= 4'd1) begin
            cool_d  = 4'd0;
            state_d = IDLE;
          end else begin
            cool_d = cool_q - 4'd1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (flight_end) begin
`ifdef MISSILE_COOLDOWN_EN
      state_d = COOL;
      cool_d  = cooldown_p;
`else
      state_d = IDLE;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      fire_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      top_q   <= '0;
      bot_q   <= '0;
      hit_q   <= '0;
      miss_q  <= 1'b0;
`ifdef MISSILE_COOLDOWN_EN
      cool_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      fire_q  <= fire_i;
      left_q  <= left_d;
      right_q <= right_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
`ifdef MISSILE_COOLDOWN_EN
      cool_q  <= cool_d;
`endif
    end
  end

  assign hit_o    = hit_q;
  assign miss_o   = miss_q;
  assign active_o = (state_q == FLY);
  assign left_o   = left_q;
  assign right_o  = right_q;
  assign top_o    = top_q;
  assign bot_o    = bot_q;
  assign color_o  = color_p;

endmodule

`default_nettype wire
